// File: rtl/mux4to1_structural_pkg.sv
// Shared constants for the gate-level 4:1 mux slice.
package mux_pkg;
  localparam int   NUM_LANES = 4;
  localparam int   SEL_W     = 2;
  localparam logic RST_VAL   = 1'b0;
endpackage

// File: rtl/mux4to1_structural_if.sv
// Lane/select bus into the mux and registered result back out.
interface mux4to1_structural_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
);
  logic [NUM_LANES*WIDTH-1:0] in_i;
  logic [SEL_W-1:0]           sel_i;
  logic [WIDTH-1:0]           out_o;

  modport master (output in_i, output sel_i, input  out_o);
  modport slave  (input  in_i, input  sel_i, output out_o);
endinterface

// File: rtl/mux4to1_structural_gate.sv
// 1-bit 2:1 mux from primitives: y = (~s & a) | (s & b).
module mux_2to1_gate (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  logic s_n, a_t, b_t;

  not u_not (s_n, s);
  and u_and_a (a_t, s_n, a);
  and u_and_b (b_t, s, b);
  or  u_or (y, a_t, b_t);
endmodule

// File: rtl/mux4to1_structural.sv
// Bit-sliced 4:1 gate mux tree feeding a single async-reset output register.
module mux4to1_structural
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mux4to1_structural_if.slave  bus
);
  logic [WIDTH-1:0] lo_y, hi_y, out_d, out_q;

  // sel[0] resolves each lane pair, sel[1] picks between the pairs.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    mux_2to1_gate u_lo (
      .a(bus.in_i[0*WIDTH+i]), .b(bus.in_i[1*WIDTH+i]), .s(bus.sel_i[0]), .y(lo_y[i])
    );
    mux_2to1_gate u_hi (
      .a(bus.in_i[2*WIDTH+i]), .b(bus.in_i[3*WIDTH+i]), .s(bus.sel_i[0]), .y(hi_y[i])
    );
    mux_2to1_gate u_top (
      .a(lo_y[i]), .b(hi_y[i]), .s(bus.sel_i[1]), .y(out_d[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= {WIDTH{RST_VAL}};
    else     out_q <= out_d;
  end

  assign bus.out_o = out_q;
endmodule

// File: tb/tb_mux4to1_structural.sv
// Directed checks of the registered 4:1 gate mux at WIDTH=1.
module tb_mux4to1_structural;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mux4to1_structural_if #(.WIDTH(1)) bus ();

  mux4to1_structural #(.WIDTH(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    bus.in_i = 4'h1; bus.sel_i = 2'd0;
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_o !== 1'b0) begin bad++; $display("FAIL reset_immediate out=%b exp=0", bus.out_o); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if (bus.out_o !== 1'b0) begin bad++; $display("FAIL reset_hold cyc=%0d out=%b exp=0", c, bus.out_o); end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_i = 4'h0;
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    total++;
    if (bus.out_o !== 1'b0) begin bad++; $display("FAIL in0_sel0 out=%b exp=0", bus.out_o); end
    @(negedge clk);
    bus.in_i = 4'h1; bus.sel_i = 2'd0;
    #1;
    total++;
    if (bus.out_o !== 1'b0) begin bad++; $display("FAIL latency_before_edge out=%b exp=0", bus.out_o); end
    @(posedge clk); #1;
    total++;
    if (bus.out_o !== 1'b1) begin bad++; $display("FAIL in1_sel0 out=%b exp=1", bus.out_o); end
    @(negedge clk);
    bus.in_i = 4'h0; bus.sel_i = 2'd1;
    @(posedge clk); #1;
    total++;
    if (bus.out_o !== 1'b0) begin bad++; $display("FAIL in0_sel1 out=%b exp=0", bus.out_o); end
    @(negedge clk);
    bus.in_i = 4'h1; bus.sel_i = 2'd1;
    @(posedge clk); #1;
    total++;
    if (bus.out_o !== 1'b0) begin bad++; $display("FAIL in1_sel1 out=%b exp=0", bus.out_o); end
  endtask

  task automatic test_onehot();
    logic [3:0] pat;
    logic       exp;
    for (int inv = 0; inv < 2; inv++) begin
      for (int h = 0; h < 4; h++) begin
        for (int s = 0; s < 4; s++) begin
          pat = 4'h1 << h;
          exp = (s == h);
          if (inv != 0) begin
            pat = ~pat;
            exp = ~exp;
          end
          @(negedge clk);
          bus.in_i = pat; bus.sel_i = 2'(s);
          @(posedge clk); #1;
          total++;
          if (bus.out_o !== exp)
            begin bad++; $display("FAIL onehot in=%h sel=%0d out=%b exp=%b", pat, s, bus.out_o, exp); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    // Inputs change every cycle, plus a glitch between edges that must be ignored.
    logic [3:0] pats [4] = '{4'h8, 4'h4, 4'h2, 4'h1};
    logic [1:0] sels [4] = '{2'd3, 2'd1, 2'd1, 2'd2};
    logic       exps [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.in_i = ~pats[k]; bus.sel_i = ~sels[k];
      #2;
      bus.in_i = pats[k]; bus.sel_i = sels[k];
      @(posedge clk); #1;
      total++;
      if (bus.out_o !== exps[k])
        begin bad++; $display("FAIL b2b k=%0d out=%b exp=%b", k, bus.out_o, exps[k]); end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    bus.in_i = 4'hF; bus.sel_i = 2'd3;
    @(posedge clk); #1;
    total++;
    if (bus.out_o !== 1'b1) begin bad++; $display("FAIL midrst_pre out=%b exp=1", bus.out_o); end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (bus.out_o !== 1'b0) begin bad++; $display("FAIL midrst_async out=%b exp=0", bus.out_o); end
    bus.in_i = 4'h0;
    #1 bus.in_i = 4'hF;
    #1 rst = 1'b0;
    #1;
    total++;
    if (bus.out_o !== 1'b0) begin bad++; $display("FAIL midrst_released out=%b exp=0", bus.out_o); end
    @(posedge clk); #1;
    total++;
    if (bus.out_o !== 1'b1) begin bad++; $display("FAIL midrst_reload out=%b exp=1", bus.out_o); end
  endtask

  initial begin
    bus.in_i  = 4'h0;
    bus.sel_i = 2'd0;
    test_reset();
    test_basic();
    test_onehot();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
